lives_manager: RTL and testbench

- Tracks the player's remaining lives (0..3) and drives the per-heart enable mask consumed by the heart-drawing graphics stage.
- Detects rising edges of the maze-collision flag, decrements lives, and opens a frame-counted invulnerability window during which the lost heart blinks.
- Flags game over when lives reach zero; a restart pulse refills lives.
- Sits between the collision detector/VGA sync and the heart graphics generator.

---
 rtl/lives_manager.sv | 128 ++++++++++++
 tb/tb_lives_manager.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lives_manager.sv
// rtl/lives_manager.sv - player lives counter with hit invulnerability window and heart blink mask
module lives_manager #(
  parameter int MAX_LIVES     = 3,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       collision,
  input  logic       restart,
  output logic [1:0] lives,
  output logic [2:0] heart_on,
  output logic       blink_on,
  output logic       hit_pulse,
  output logic       game_over
);

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    INVULN    = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [7:0] INV_LOAD   = 8'(INVULN_FRAMES);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  state_t     state;
  logic       col_q;
  logic [7:0] inv_cnt;
  logic [7:0] blink_cnt;
  logic       phase;
  logic       hit_edge;

  // A held collision only counts on its first cycle.
  assign hit_edge = collision & ~col_q;

  // Hearts below the life count are lit; while blinking, the heart just lost shows the blink phase.
  function automatic logic [2:0] heart_mask(input logic [1:0] n, input logic show_lost,
                                            input logic ph);
    logic [2:0] m;
    m = 3'b000;
    for (int i = 0; i < 3; i++) begin
      m[i] = (i < MAX_LIVES) && ((2'(i) < n) || (show_lost && (2'(i) == n) && ph));
    end
    return m;
  endfunction

  // Lives FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ALIVE;
      col_q     <= 1'b0;
      inv_cnt   <= 8'd0;
      blink_cnt <= 8'd0;
      phase     <= 1'b0;
      lives     <= LIVES_INIT;
      heart_on  <= heart_mask(LIVES_INIT, 1'b0, 1'b0);
      blink_on  <= 1'b0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
    end else begin
      col_q     <= collision;
      hit_pulse <= 1'b0;
      if (restart) begin
        state     <= ALIVE;
        inv_cnt   <= 8'd0;
        blink_cnt <= 8'd0;
        phase     <= 1'b0;
        lives     <= LIVES_INIT;
        heart_on  <= heart_mask(LIVES_INIT, 1'b0, 1'b0);
        blink_on  <= 1'b0;
        game_over <= 1'b0;
      end else begin
        case (state)
          ALIVE: begin
            if (hit_edge) begin
              hit_pulse <= 1'b1;
              lives     <= lives - 2'd1;
              if (lives == 2'd1) begin
                state     <= GAME_OVER;
                game_over <= 1'b1;
                heart_on  <= 3'b000;
                blink_on  <= 1'b0;
              end else begin
                state     <= INVULN;
                inv_cnt   <= INV_LOAD;
                blink_cnt <= 8'd0;
                phase     <= 1'b0;
                blink_on  <= 1'b1;
                heart_on  <= heart_mask(lives - 2'd1, 1'b1, 1'b0);
              end
            end
          end
          INVULN: begin
            if (frame_tick) begin
              if (inv_cnt == 8'd1) begin
                state     <= ALIVE;
                inv_cnt   <= 8'd0;
                blink_cnt <= 8'd0;
                phase     <= 1'b0;
                blink_on  <= 1'b0;
                heart_on  <= heart_mask(lives, 1'b0, 1'b0);
              end else begin
                inv_cnt <= inv_cnt - 8'd1;
                if (blink_cnt == BLINK_LAST) begin
                  blink_cnt <= 8'd0;
                  phase     <= ~phase;
                  heart_on  <= heart_mask(lives, 1'b1, ~phase);
                end else begin
                  blink_cnt <= blink_cnt + 8'd1;
                end
              end
            end
          end
          GAME_OVER: begin
            game_over <= 1'b1;
          end
          default: begin
            state <= ALIVE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lives_manager.sv
// tb/tb_lives_manager.sv - randomized scoreboard bench for lives_manager
module tb_lives_manager;

  localparam int MAXL  = 3;
  localparam int INV   = 60;
  localparam int BLK   = 8;
  localparam int FRAME = 4;

  logic       clk = 1'b0;
  logic       reset, frame_tick, collision, restart;
  logic [1:0] lives;
  logic [2:0] heart_on;
  logic       blink_on, hit_pulse, game_over;

  lives_manager #(
    .MAX_LIVES    (MAXL),
    .INVULN_FRAMES(INV),
    .BLINK_FRAMES (BLK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .collision (collision),
    .restart   (restart),
    .lives     (lives),
    .heart_on  (heart_on),
    .blink_on  (blink_on),
    .hit_pulse (hit_pulse),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lives;
    logic [2:0] heart;
    logic       blink;
    logic       hit;
    logic       over;
  } exp_t;

  exp_t exp_q[$];
  int   errors  = 0;
  int   checks  = 0;
  int   cyc_cnt = 0;

  // Reference model: lives count, frames of immunity left, frames since the hit.
  int m_lives = MAXL;
  int m_inv   = 0;
  int m_ticks = 0;
  bit m_prev  = 0;
  bit m_over  = 0;
  bit m_hit   = 0;

  bit drv_col     = 0;
  bit drv_restart = 0;
  bit drv_reset   = 0;
  bit rand_tick   = 0;

  task automatic cyc();
    bit   tk, hit_e;
    exp_t e;
    tk = rand_tick ? ($urandom_range(0, 3) == 0) : ((cyc_cnt % FRAME) == FRAME - 1);
    reset      = drv_reset;
    collision  = drv_col;
    restart    = drv_restart;
    frame_tick = tk;

    m_hit = 0;
    if (!drv_reset) begin
      m_lives = MAXL; m_inv = 0; m_ticks = 0; m_over = 0; m_prev = 0;
    end else begin
      hit_e  = drv_col && !m_prev;
      m_prev = drv_col;
      if (drv_restart) begin
        m_lives = MAXL; m_inv = 0; m_ticks = 0; m_over = 0;
      end else if (m_over) begin
        m_over = 1;
      end else if (m_inv > 0) begin
        if (tk) begin
          m_inv--;
          m_ticks++;
        end
      end else if (hit_e) begin
        m_lives--;
        m_hit = 1;
        if (m_lives == 0) m_over = 1;
        else begin
          m_inv   = INV;
          m_ticks = 0;
        end
      end
    end

    e.lives = 2'(m_lives);
    for (int i = 0; i < 3; i++)
      e.heart[i] = (i < m_lives) ||
                   ((m_inv > 0) && (i == m_lives) && (((m_ticks / BLK) % 2) == 1));
    e.blink = (m_inv > 0);
    e.hit   = m_hit;
    e.over  = m_over;
    exp_q.push_back(e);
    cyc_cnt++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic align_tick();
    while ((cyc_cnt % FRAME) != FRAME - 1) cyc();
  endtask

  // Monitor: each cycle the registered outputs are compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t ex, ac;
    if (exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      ac = {lives, heart_on, blink_on, hit_pulse, game_over};
      checks++;
      if (ac !== ex) begin
        errors++;
        $display("FAIL outputs t=%0t: got lives=%0d heart=%b blink=%b hit=%b over=%b, need lives=%0d heart=%b blink=%b hit=%b over=%b",
                 $time, ac.lives, ac.heart, ac.blink, ac.hit, ac.over,
                 ex.lives, ex.heart, ex.blink, ex.hit, ex.over);
      end
    end
  end

  initial begin
    // reset, then idle frames
    drv_reset = 0; run(3);
    drv_reset = 1; run(5 * FRAME);
    // single hit, watch the blink through the whole window
    drv_col = 1; run(2);
    drv_col = 0; run(70 * FRAME);
    // collision held for 100 frames counts once
    drv_col = 1; run(100 * FRAME);
    drv_col = 0; run(10);
    // final hit -> game over, further collisions ignored
    drv_col = 1; run(3);
    drv_col = 0; run(3);
    drv_col = 1; run(3);
    drv_col = 0; run(3 * FRAME);
    // restart from game over
    drv_restart = 1; run(1);
    drv_restart = 0; run(4);
    // restart coincident with a collision edge
    drv_col = 1; drv_restart = 1; run(1);
    drv_restart = 0; run(3);
    drv_col = 0; run(3);
    // hit on a frame tick, reset 30 frames into the window
    align_tick();
    drv_col = 1; run(1);
    drv_col = 0; run(30 * FRAME - 1);
    drv_reset = 0; run(1);
    drv_reset = 1; run(4);
    // hit on a frame tick, full window
    align_tick();
    drv_col = 1; run(1);
    drv_col = 0; run(65 * FRAME);
    // randomized traffic
    rand_tick = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) drv_col = ~drv_col;
      drv_restart = ($urandom_range(0, 149) == 0);
      drv_reset   = !($urandom_range(0, 399) == 0);
      cyc();
    end
    drv_reset = 1; drv_restart = 0; drv_col = 0;
    run(2);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
